imem_fetch_port: RTL

IMEM_FETCH_PORT -- requirements
Module: imem_fetch_port

---
 rtl/imem_fetch_port.sv | 62 ++++++
 1 files changed

// File: rtl/imem_fetch_port.sv
// Instruction memory fetch port: word-addressed load path plus a single-entry
// registered fetch response with valid/ready handshake and never-loaded detection.
module imem_fetch_port #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  loaded;
    logic              accept;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // A word written while reset is high stays unreadable: its loaded bit is
    // held clear, so the array itself needs no reset qualification.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loaded    <= '0;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= req_addr;
                rsp_err   <= !loaded[req_addr];
                rsp_instr <= loaded[req_addr] ? mem[req_addr] : NOP_WORD;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (ld_en) begin
                loaded[ld_addr] <= 1'b1;
            end
        end
    end

endmodule
